// File: rtl/e203_exu_bjp_resolve_pkg.sv
// Shared constants and types for the branch/jump resolve block.
package e203_exu_bjp_resolve_pkg;

   localparam int unsigned E203_PC_SIZE = 32;
   localparam int unsigned BJP_CNT_W    = 16;
   localparam int unsigned STATE_W      = 1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Flush target adder operands captured on a mispredict.
   typedef struct packed {
      logic [E203_PC_SIZE-1:0] op1;
      logic [E203_PC_SIZE-1:0] op2;
   } flush_tgt_t;

endpackage

// File: rtl/e203_exu_bjp_resolve_satcnt.sv
// 16-bit counter that increments on inc and sticks at all-ones.
module e203_exu_bjp_satcnt
   import e203_exu_bjp_resolve_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [BJP_CNT_W-1:0] cnt
);

   logic                 at_max;
   logic [BJP_CNT_W-1:0] cnt_nxt;

   assign at_max  = &cnt;
   assign cnt_nxt = cnt + BJP_CNT_W'(1);

   sirv_gnrl_dfflr #(.DW(BJP_CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (inc & ~at_max),
      .dnxt  (cnt_nxt),
      .qout  (cnt)
   );

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// General-purpose flop with load enable and async active-low reset to zero.
module sirv_gnrl_dfflr #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) qout <= '0;
      else if (lden) qout <= dnxt;
   end

endmodule

// File: rtl/e203_exu_bjp_resolve.sv
// Branch/jump resolution: commits correct predictions, requests an IFU flush
// on a mispredict and keeps saturating branch/mispredict statistics.
module e203_exu_bjp_resolve
   import e203_exu_bjp_resolve_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bjp_i_valid,
   output logic                    bjp_i_ready,
   input  logic                    bjp_i_prdt_taken,
   input  logic                    bjp_i_rslv_taken,
   input  logic [E203_PC_SIZE-1:0] bjp_i_tgt_op1,
   input  logic [E203_PC_SIZE-1:0] bjp_i_tgt_op2,
   output logic                    flush_req,
   input  logic                    flush_ack,
   output logic [E203_PC_SIZE-1:0] flush_add_op1,
   output logic [E203_PC_SIZE-1:0] flush_add_op2,
   input  logic                    kill,
   output logic                    cmt_valid,
   output logic                    cmt_mispred,
   output logic [BJP_CNT_W-1:0]    bjp_cnt,
   output logic [BJP_CNT_W-1:0]    mispred_cnt
);

   logic [STATE_W-1:0] state_r;
   state_e             state_q;
   state_e             state_nxt;
   logic               accept;
   logic               mispred;
   logic               tgt_ld;
   logic               cmt_set;
   logic               cmt_mis_nxt;
   flush_tgt_t         tgt_d;
   flush_tgt_t         tgt_q;

   assign state_q     = state_e'(state_r);
   assign bjp_i_ready = (state_q == ST_IDLE) & ~kill;
   assign accept      = bjp_i_valid & bjp_i_ready;
   assign mispred     = bjp_i_prdt_taken ^ bjp_i_rslv_taken;
   assign flush_req   = (state_q == ST_FLUSH);

   // Next state and commit decision; kill outranks a same-cycle ack.
   always_comb begin
      state_nxt   = state_q;
      tgt_ld      = 1'b0;
      cmt_set     = 1'b0;
      cmt_mis_nxt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (mispred) begin
                  tgt_ld    = 1'b1;
                  state_nxt = ST_FLUSH;
               end else begin
                  cmt_set = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if (flush_ack) begin
               state_nxt   = ST_IDLE;
               cmt_set     = 1'b1;
               cmt_mis_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   sirv_gnrl_dfflr #(.DW(STATE_W)) u_state (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (1'b1),
      .dnxt  (STATE_W'(state_nxt)),
      .qout  (state_r)
   );

   assign tgt_d = '{op1: bjp_i_tgt_op1, op2: bjp_i_tgt_op2};

   sirv_gnrl_dfflr #(.DW($bits(flush_tgt_t))) u_tgt (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (tgt_ld),
      .dnxt  (tgt_d),
      .qout  (tgt_q)
   );

   assign flush_add_op1 = tgt_q.op1;
   assign flush_add_op2 = tgt_q.op2;

   sirv_gnrl_dfflr #(.DW(2)) u_cmt (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (1'b1),
      .dnxt  ({cmt_set, cmt_mis_nxt}),
      .qout  ({cmt_valid, cmt_mispred})
   );

   // Counters advance on the same edge that raises cmt_valid.
   e203_exu_bjp_satcnt u_bjp_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cmt_set),
      .cnt   (bjp_cnt)
   );

   e203_exu_bjp_satcnt u_mispred_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cmt_set & cmt_mis_nxt),
      .cnt   (mispred_cnt)
   );

endmodule

// File: tb/tb_e203_exu_bjp_resolve.sv
// Scoreboard bench for e203_exu_bjp_resolve: stimulus queues expected commits,
// a negedge monitor pops and compares each cmt pulse.
module tb_e203_exu_bjp_resolve;
   import e203_exu_bjp_resolve_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bjp_i_valid, bjp_i_ready, bjp_i_prdt_taken, bjp_i_rslv_taken;
   logic [31:0] bjp_i_tgt_op1, bjp_i_tgt_op2, flush_add_op1, flush_add_op2;
   logic        flush_req, flush_ack, kill, cmt_valid, cmt_mispred;
   logic [15:0] bjp_cnt, mispred_cnt;

   typedef struct packed {
      logic        mis;
      logic [15:0] bjp;
      logic [15:0] mcnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] exp_bjp, exp_mis;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   e203_exu_bjp_resolve dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .bjp_i_valid      (bjp_i_valid),
      .bjp_i_ready      (bjp_i_ready),
      .bjp_i_prdt_taken (bjp_i_prdt_taken),
      .bjp_i_rslv_taken (bjp_i_rslv_taken),
      .bjp_i_tgt_op1    (bjp_i_tgt_op1),
      .bjp_i_tgt_op2    (bjp_i_tgt_op2),
      .flush_req        (flush_req),
      .flush_ack        (flush_ack),
      .flush_add_op1    (flush_add_op1),
      .flush_add_op2    (flush_add_op2),
      .kill             (kill),
      .cmt_valid        (cmt_valid),
      .cmt_mispred      (cmt_mispred),
      .bjp_cnt          (bjp_cnt),
      .mispred_cnt      (mispred_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic push_exp(input logic mis);
      exp_t e;
      exp_bjp = sat_inc(exp_bjp);
      if (mis) exp_mis = sat_inc(exp_mis);
      e.mis  = mis;
      e.bjp  = exp_bjp;
      e.mcnt = exp_mis;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic prdt, input logic rslv, input logic [31:0] op1, input logic [31:0] op2);
      bjp_i_valid      = 1'b1;
      bjp_i_prdt_taken = prdt;
      bjp_i_rslv_taken = rslv;
      bjp_i_tgt_op1    = op1;
      bjp_i_tgt_op2    = op2;
   endtask

   // Monitor: every cmt pulse must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && cmt_valid) begin
         if (exp_q.size() == 0) begin
            check("cmt_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("cmt", 64'({cmt_mispred, bjp_cnt, mispred_cnt}), 64'(e));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bjp_i_valid = 1'b0; bjp_i_prdt_taken = 1'b0; bjp_i_rslv_taken = 1'b0;
      bjp_i_tgt_op1 = '0; bjp_i_tgt_op2 = '0; flush_ack = 1'b0; kill = 1'b0;
      exp_bjp = '0; exp_mis = '0;
      #12;
      check("rst_flush_req", 64'(flush_req), 64'd0);
      check("rst_cmt_valid", 64'(cmt_valid), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("rst_ready", 64'(bjp_i_ready), 64'd1);
      check("rst_cnts", 64'({bjp_cnt, mispred_cnt}), 64'd0);
      check("rst_ops", 64'({flush_add_op1, flush_add_op2}), 64'd0);

      // Correct prediction
      present(1'b1, 1'b1, 32'h1111_0000, 32'h4);
      check("ok_ready", 64'(bjp_i_ready), 64'd1);
      push_exp(1'b0);
      tick();
      bjp_i_valid = 1'b0;
      check("ok_no_flush", 64'(flush_req), 64'd0);

      // Mispredict with a delayed ack; inputs change but held ops must not
      present(1'b0, 1'b1, 32'h8000_0100, 32'h0000_0040);
      tick();
      bjp_i_valid = 1'b0; bjp_i_tgt_op1 = 32'hDEAD_BEEF; bjp_i_tgt_op2 = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         check("mp_flush_req", 64'(flush_req), 64'd1);
         check("mp_ready", 64'(bjp_i_ready), 64'd0);
         check("mp_op1", 64'(flush_add_op1), 64'h8000_0100);
         check("mp_op2", 64'(flush_add_op2), 64'h0000_0040);
         tick();
      end
      flush_ack = 1'b1;
      push_exp(1'b1);
      tick();
      flush_ack = 1'b0;
      check("mp_exit_flush", 64'(flush_req), 64'd0);
      check("mp_exit_ready", 64'(bjp_i_ready), 64'd1);

      // Kill and ack together in FLUSH: kill wins, nothing commits
      present(1'b1, 1'b0, 32'h2000_0000, 32'h8);
      tick();
      bjp_i_valid = 1'b0;
      check("kill_in_flush", 64'(flush_req), 64'd1);
      kill = 1'b1; flush_ack = 1'b1;
      tick();
      kill = 1'b0; flush_ack = 1'b0;
      check("kill_exit", 64'(flush_req), 64'd0);
      check("kill_cnts", 64'({bjp_cnt, mispred_cnt}), 64'({exp_bjp, exp_mis}));

      // Kill in IDLE blocks accept; stray ack in IDLE is ignored
      kill = 1'b1;
      present(1'b0, 1'b1, 32'h3000_0000, 32'h0);
      check("idle_kill_ready", 64'(bjp_i_ready), 64'd0);
      tick();
      kill = 1'b0; bjp_i_valid = 1'b0;
      check("idle_kill_state", 64'(flush_req), 64'd0);
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      check("idle_ack_ignored", 64'(flush_req), 64'd0);
      check("idle_cnts", 64'({bjp_cnt, mispred_cnt}), 64'({exp_bjp, exp_mis}));

      // Back-to-back: mispredict, then a correct branch held valid
      present(1'b0, 1'b1, 32'h4000_0000, 32'h10);
      tick();
      present(1'b1, 1'b1, 32'h0, 32'h0);
      check("b2b_blocked", 64'(bjp_i_ready), 64'd0);
      tick();
      flush_ack = 1'b1;
      push_exp(1'b1);
      tick();
      flush_ack = 1'b0;
      check("b2b_ready_after_ack", 64'(bjp_i_ready), 64'd1);
      push_exp(1'b0);
      tick();
      bjp_i_valid = 1'b0;
      tick();
      check("b2b_cnts", 64'({bjp_cnt, mispred_cnt}), 64'({16'd4, 16'd2}));

      // Reset mid-FLUSH acts asynchronously
      present(1'b0, 1'b1, 32'h1234_5678, 32'h9);
      tick();
      bjp_i_valid = 1'b0;
      check("rf_flush_req", 64'(flush_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rf_async_flush", 64'(flush_req), 64'd0);
      check("rf_async_ops", 64'({flush_add_op1, flush_add_op2}), 64'd0);
      check("rf_async_cnts", 64'({bjp_cnt, mispred_cnt}), 64'd0);
      exp_bjp = '0; exp_mis = '0;
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("rf_ready", 64'(bjp_i_ready), 64'd1);
      tick();
      check("rf_idle", 64'(flush_req), 64'd0);

      // Saturation: 65536 correct branches, then one mispredict
      present(1'b1, 1'b1, 32'h0, 32'h0);
      for (int i = 0; i < 65536; i++) begin
         push_exp(1'b0);
         tick();
      end
      bjp_i_valid = 1'b0;
      check("sat_bjp", 64'(bjp_cnt), 64'hFFFF);
      present(1'b1, 1'b0, 32'h5000_0000, 32'h0);
      tick();
      bjp_i_valid = 1'b0;
      flush_ack = 1'b1;
      push_exp(1'b1);
      tick();
      flush_ack = 1'b0;
      check("sat_hold", 64'({bjp_cnt, mispred_cnt}), 64'({16'hFFFF, 16'd1}));

      tick();
      tick();
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
